// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and character helpers for the LCD screen composers.
package lcd_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_t;

    // Decimal digits always render; 10..15 render as hex letters only when enabled.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic hex_mode);
        logic [7:0] ch;
        if (nibble < 4'd10) begin
            ch = ASCII_ZERO + {4'd0, nibble};
        end else if (hex_mode) begin
            ch = ASCII_A + {4'd0, nibble} - 8'd10;
        end else begin
            ch = ASCII_SPACE;
        end
        return ch;
    endfunction

endpackage

// File: rtl/lcd_blink_timer.sv
// Free-running blink phase generator shared by the LCD screens.
module lcd_blink_timer
    import lcd_pkg::*;
#(
    parameter int BLINK_HALF_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic phase,
    output logic blink_tick
);

    localparam int CNT_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BLINK_HALF_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign blink_tick = (count == LAST_COUNT);

    // The phase flips on the same edge that wraps the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            phase <= 1'b0;
        end else if (blink_tick) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Composes a two-line title/digit frame from a coherent snapshot and streams it
// one character per handshake, refreshing only when something visible changes.
module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int N_DIGITS          = 6,
    parameter int LINE_CHARS        = 16,
    parameter int TITLE_CHARS       = 10,
    parameter int TITLE_COL         = 3,
    parameter int DIGIT_COL         = 3,
    parameter int BLINK_HALF_CYCLES = 50_000_000,
    parameter int HEX_MODE          = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [4*N_DIGITS-1:0]           digits,
    input  logic [N_DIGITS-1:0]             blink_mask,
    input  logic [N_DIGITS-2:0]             sep_after,
    input  logic [7:0]                      sep_char,
    input  logic [8*TITLE_CHARS-1:0]        title,
    input  logic                            force_refresh,
    input  logic                            char_ready,
    output logic                            char_valid,
    output logic [7:0]                      char_data,
    output logic                            char_row,
    output logic [$clog2(LINE_CHARS)-1:0]   char_col,
    output logic                            frame_start,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int COL_W    = $clog2(LINE_CHARS);
    localparam int OFF_SEPC = 8 * TITLE_CHARS;
    localparam int OFF_SEP  = OFF_SEPC + 8;
    localparam int OFF_MASK = OFF_SEP + N_DIGITS - 1;
    localparam int OFF_DIG  = OFF_MASK + N_DIGITS;
    localparam int SNAP_W   = OFF_DIG + 4 * N_DIGITS;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_CHARS - 1);

    stream_state_t state;
    stream_state_t next_state;

    logic                      phase;
    logic                      blink_tick;
    logic                      init_pending;
    logic                      pending;
    logic                      start_q;
    logic [SNAP_W-1:0]         live_snap;
    logic [SNAP_W-1:0]         snap;
    logic                      snap_phase;
    logic                      row_q;
    logic [COL_W-1:0]          col_q;
    logic                      trigger;
    logic                      start_frame;
    logic                      accept;
    logic                      last_char;
    logic [7:0]                line1_char;
    logic [7:0]                line2_char;
    logic [7:0]                render_char;

    logic [8*TITLE_CHARS-1:0]  snap_title;
    logic [7:0]                snap_sep_char;
    logic [N_DIGITS-2:0]       snap_sep;
    logic [N_DIGITS-1:0]       snap_mask;
    logic [4*N_DIGITS-1:0]     snap_digits;
    logic [N_DIGITS-1:0]       sep_ext;

    lcd_blink_timer #(
        .BLINK_HALF_CYCLES(BLINK_HALF_CYCLES)
    ) u_blink_timer (
        .clk       (clk),
        .reset     (reset),
        .phase     (phase),
        .blink_tick(blink_tick)
    );

    // The snapshot doubles as the "last sent" copy used for change detection.
    assign live_snap     = {digits, blink_mask, sep_after, sep_char, title};
    assign snap_title    = snap[OFF_SEPC-1:0];
    assign snap_sep_char = snap[OFF_SEPC +: 8];
    assign snap_sep      = snap[OFF_SEP +: N_DIGITS-1];
    assign snap_mask     = snap[OFF_MASK +: N_DIGITS];
    assign snap_digits   = snap[OFF_DIG +: 4*N_DIGITS];
    assign sep_ext       = {1'b0, snap_sep};

    assign trigger     = init_pending | force_refresh | (blink_tick & (|blink_mask))
                       | (live_snap != snap);
    assign start_frame = (state == ST_IDLE) & (trigger | pending);
    assign accept      = (state == ST_STREAM) & char_ready;
    assign last_char   = row_q & (col_q == LAST_COL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start_frame) next_state = ST_STREAM;
            ST_STREAM: if (accept && last_char) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        char_valid  = (state == ST_STREAM);
        busy        = (state == ST_STREAM) || (state == ST_DONE);
        frame_done  = (state == ST_DONE);
        frame_start = start_q;
        char_row    = row_q;
        char_col    = col_q;
        char_data   = (state == ST_STREAM) ? render_char : ASCII_SPACE;
    end

    // Capture the phase that will be in effect after this edge so a blink-tick
    // refresh shows the new phase rather than the one just ending.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_pending <= 1'b1;
            pending      <= 1'b0;
            start_q      <= 1'b0;
            snap         <= '0;
            snap_phase   <= 1'b0;
            row_q        <= 1'b0;
            col_q        <= '0;
        end else begin
            start_q <= start_frame;
            if (start_frame) begin
                snap         <= live_snap;
                snap_phase   <= phase ^ blink_tick;
                init_pending <= 1'b0;
                pending      <= 1'b0;
                row_q        <= 1'b0;
                col_q        <= '0;
            end else if ((state != ST_IDLE) && trigger) begin
                pending <= 1'b1;
            end
            if (accept) begin
                if (col_q == LAST_COL) begin
                    col_q <= '0;
                    row_q <= ~row_q;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Walk the line-2 element sequence and pick whichever element lands on the
    // current column; anything placed past the last column simply never matches.
    always_comb begin
        int         col_i;
        int         pos;
        logic [3:0] nib;
        col_i      = int'(col_q);
        nib        = 4'd0;
        line1_char = ASCII_SPACE;
        for (int k = 0; k < TITLE_CHARS; k++) begin
            if (col_i == TITLE_COL + k) begin
                line1_char = snap_title[8*(TITLE_CHARS-1-k) +: 8];
            end
        end
        line2_char = ASCII_SPACE;
        pos        = DIGIT_COL;
        for (int i = 0; i < N_DIGITS; i++) begin
            nib = snap_digits[4*(N_DIGITS-1-i) +: 4];
            if (pos == col_i) begin
                line2_char = (snap_phase && snap_mask[N_DIGITS-1-i]) ? ASCII_SPACE
                           : nibble_to_ascii(nib, HEX_MODE != 0);
            end
            pos = pos + 1;
            if (sep_ext[i]) begin
                if (pos == col_i) begin
                    line2_char = snap_sep_char;
                end
                pos = pos + 1;
            end
        end
        render_char = row_q ? line2_char : line1_char;
    end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Self-checking bench for lcd_frame_streamer: a frame-level model checks every streamed character.
module tb_lcd_frame_streamer;

    localparam int BHC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [23:0] digits;
    logic [5:0]  blink_mask;
    logic [4:0]  sep_after;
    logic [7:0]  sep_char;
    logic [79:0] title;
    logic        force_refresh;
    logic        char_ready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_row;
    logic [3:0]  char_col;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    logic        hx_reset;
    logic [47:0] hx_digits;
    logic [11:0] hx_mask;
    logic [10:0] hx_sep;
    logic [7:0]  hx_sep_char;
    logic [79:0] hx_title;
    logic        hx_force;
    logic        hx_ready;
    logic        hx_valid;
    logic [7:0]  hx_data;
    logic        hx_row;
    logic [3:0]  hx_col;
    logic        hx_start;
    logic        hx_done;
    logic        hx_busy;

    lcd_frame_streamer #(
        .BLINK_HALF_CYCLES(BHC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digits       (digits),
        .blink_mask   (blink_mask),
        .sep_after    (sep_after),
        .sep_char     (sep_char),
        .title        (title),
        .force_refresh(force_refresh),
        .char_ready   (char_ready),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_row     (char_row),
        .char_col     (char_col),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    lcd_frame_streamer #(
        .N_DIGITS         (12),
        .HEX_MODE         (1),
        .BLINK_HALF_CYCLES(BHC)
    ) dut_hex (
        .clk          (clk),
        .reset        (hx_reset),
        .digits       (hx_digits),
        .blink_mask   (hx_mask),
        .sep_after    (hx_sep),
        .sep_char     (hx_sep_char),
        .title        (hx_title),
        .force_refresh(hx_force),
        .char_ready   (hx_ready),
        .char_valid   (hx_valid),
        .char_data    (hx_data),
        .char_row     (hx_row),
        .char_col     (hx_col),
        .frame_start  (hx_start),
        .frame_done   (hx_done),
        .busy         (hx_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Frame model: char k of the 32-char frame lives at bits [8k +: 8].
    function automatic logic [255:0] model_frame(input int n, input bit hex, input logic [47:0] dg,
                                                 input logic [11:0] mk, input logic [10:0] sp,
                                                 input logic [7:0] sc, input logic [79:0] tt, input bit ph);
        logic [255:0] f;
        logic [3:0]   nib;
        logic [7:0]   ch;
        int           pos;
        for (int k = 0; k < 32; k++) f[8*k +: 8] = 8'h20;
        for (int k = 0; k < 10; k++) begin
            if (3 + k < 16) f[8*(3+k) +: 8] = tt[8*(9-k) +: 8];
        end
        pos = 3;
        for (int i = 0; i < n; i++) begin
            nib = dg[4*(n-1-i) +: 4];
            if (ph && mk[n-1-i])  ch = 8'h20;
            else if (nib < 4'd10) ch = 8'h30 + {4'd0, nib};
            else if (hex)         ch = 8'h41 + {4'd0, nib} - 8'd10;
            else                  ch = 8'h20;
            if (pos < 16) f[8*(16+pos) +: 8] = ch;
            pos++;
            if (i < n - 1 && sp[i]) begin
                if (pos < 16) f[8*(16+pos) +: 8] = sc;
                pos++;
            end
        end
        return f;
    endfunction

    function automatic logic [127:0] line_of(input logic [255:0] f, input int row);
        logic [127:0] s;
        for (int c = 0; c < 16; c++) s[8*(15-c) +: 8] = f[8*(row*16+c) +: 8];
        return s;
    endfunction

    int cyc     = 0;
    int n_since = 0;
    always @(posedge clk) begin
        cyc++;
        if (reset) n_since = 0;
        else       n_since++;
    end

    bit           in_frame    = 0;
    bit           done_expect = 0;
    int           idx         = 0;
    int           start_count = 0;
    int           done_count  = 0;
    int           start_cyc   = 0;
    int           done_cyc    = 0;
    int           count_blank = 0;
    int           count_full  = 0;
    logic [255:0] exp_frame, rx_cur, last_rx;
    logic [23:0]  p_digits;
    logic [5:0]   p_mask;
    logic [4:0]   p_sep;
    logic [7:0]   p_sep_char;
    logic [79:0]  p_title;
    bit           p_valid = 0;
    bit           p_ready = 0;
    logic [7:0]   p_data;
    logic         p_row;
    logic [3:0]   p_col;
    int           hx_idx     = 0;
    int           hx_accepts = 0;
    logic [255:0] hx_exp, hx_rx;

    // Compare process: every cycle outside reset, outputs are checked against the frame model.
    always @(negedge clk) begin
        if (reset) begin
            in_frame    = 0;
            done_expect = 0;
            p_valid     = 0;
        end else begin
            check_output("frame_done_timing", frame_done, done_expect);
            check_output("busy", busy, char_valid | frame_done);
            done_expect = 0;
            if (frame_done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (frame_start) begin
                check_output("start_with_first_char", {char_valid, in_frame, char_row, char_col},
                             {1'b1, 1'b0, 1'b0, 4'd0});
                exp_frame = model_frame(6, 0, {24'd0, p_digits}, {6'd0, p_mask}, {6'd0, p_sep},
                                        p_sep_char, p_title, ((n_since / BHC) % 2) == 1);
                in_frame  = 1;
                idx       = 0;
                start_count++;
                start_cyc = cyc;
            end
            if (char_valid) begin
                check_output("in_frame_when_valid", in_frame, 1'b1);
                if (in_frame) begin
                    check_output("char", {char_data, char_row, char_col},
                                 {exp_frame[8*idx +: 8], 1'(idx / 16), 4'(idx % 16)});
                    if (p_valid && !p_ready)
                        check_output("stall_stable", {char_data, char_row, char_col}, {p_data, p_row, p_col});
                    if (char_ready) begin
                        rx_cur[8*idx +: 8] = char_data;
                        idx++;
                        if (idx == 32) begin
                            in_frame    = 0;
                            done_expect = 1;
                            last_rx     = rx_cur;
                            if (line_of(rx_cur, 1) == "   12:34:       ") count_blank++;
                            if (line_of(rx_cur, 1) == "   12:34:56     ") count_full++;
                        end
                    end
                end
            end else if (in_frame) begin
                check_output("valid_held_in_frame", char_valid, 1'b1);
            end
            p_valid = char_valid;
            p_ready = char_ready;
            p_data  = char_data;
            p_row   = char_row;
            p_col   = char_col;
        end
        p_digits   = digits;
        p_mask     = blink_mask;
        p_sep      = sep_after;
        p_sep_char = sep_char;
        p_title    = title;

        if (!hx_reset) begin
            if (hx_start) begin
                hx_exp = model_frame(12, 1, hx_digits, hx_mask, hx_sep, hx_sep_char, hx_title, 0);
                hx_idx = 0;
            end
            if (hx_valid && hx_ready) begin
                hx_accepts++;
                if (hx_idx < 32) begin
                    check_output("hex_char", {hx_data, hx_row, hx_col},
                                 {hx_exp[8*hx_idx +: 8], 1'(hx_idx / 16), 4'(hx_idx % 16)});
                    hx_rx[8*hx_idx +: 8] = hx_data;
                    hx_idx++;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic first_ready);
        @(posedge clk); #1;
        force_refresh = 1'b1;
        @(posedge clk); #1;
        force_refresh = 1'b0;
        char_ready    = first_ready;
    endtask

    task automatic wait_frames(input int target, input int bound, input string name);
        int k = 0;
        while (done_count < target && k < bound) begin
            @(posedge clk);
            k++;
        end
        check_output({name, "_done_reached"}, done_count >= target, 1'b1);
    endtask

    task automatic wait_char(input int target, input int bound, input string name);
        int k = 0;
        while (!(in_frame && idx >= target) && k < bound) begin
            @(posedge clk);
            k++;
        end
        check_output({name, "_char_reached"}, in_frame && idx >= target, 1'b1);
    endtask

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int s;
        int st;
        reset         = 1'b1;
        hx_reset      = 1'b1;
        digits        = 24'h123456;
        blink_mask    = 6'b000000;
        sep_after     = 5'b01010;
        sep_char      = ":";
        title         = "   CLOCK  ";
        force_refresh = 1'b0;
        char_ready    = 1'b1;
        hx_digits     = 48'hA0B1C2D3E4F5;
        hx_mask       = 12'd0;
        hx_sep        = 11'h7FF;
        hx_sep_char   = ":";
        hx_title      = "HEX TEST  ";
        hx_force      = 1'b0;
        hx_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state", {char_valid, frame_start, frame_done, busy, char_data, char_row, char_col},
                     {4'b0000, 8'h20, 1'b0, 4'd0});

        check_output("model_pin_line1", line_of(model_frame(6, 0, 48'h123456, 12'd0, 11'b01010, ":",
                     "   CLOCK  ", 0), 0), "      CLOCK     ");
        check_output("model_pin_blank", line_of(model_frame(6, 0, 48'h123456, 12'b000011, 11'b01010, ":",
                     "   CLOCK  ", 1), 1), "   12:34:       ");
        check_output("model_pin_hex", line_of(model_frame(12, 1, 48'hA0B1C2D3E4F5, 12'd0, 11'h7FF, ":",
                     "HEX TEST  ", 0), 1), "   A:0:B:1:C:2:D");

        @(posedge clk); #1;
        reset    = 1'b0;
        hx_reset = 1'b0;

        $display("[TB] post-reset frame");
        wait_frames(1, 100, "first_frame");
        check_output("first_line1", line_of(last_rx, 0), "      CLOCK     ");
        check_output("first_line2", line_of(last_rx, 1), "   12:34:56     ");
        check_output("first_duration", done_cyc - start_cyc, 32);
        repeat (20) @(posedge clk);
        check_output("idle_after_first", start_count, 1);

        $display("[TB] backpressure");
        apply_stimulus(1'b0);
        begin
            int k = 0;
            while (done_count < 2 && k < 200) begin
                @(posedge clk); #1;
                char_ready = ~char_ready;
                k++;
            end
        end
        check_output("bp_done_reached", done_count, 2);
        check_output("bp_duration", done_cyc - start_cyc, 64);
        check_output("bp_line2", line_of(last_rx, 1), "   12:34:56     ");
        char_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] blink");
        s = start_count;
        #1;
        blink_mask = 6'b000011;
        repeat (300) @(posedge clk);
        check_output("blink_frames_run", (start_count - s) >= 7, 1'b1);
        check_output("blink_blank_seen", count_blank > 0, 1'b1);
        check_output("blink_full_seen", count_full > 1, 1'b1);
        #1;
        blink_mask = 6'b000000;
        repeat (120) @(posedge clk);
        s = start_count;
        repeat (60) @(posedge clk);
        check_output("no_frames_mask_off", start_count, s);
        check_output("mask_off_line2", line_of(last_rx, 1), "   12:34:56     ");

        $display("[TB] mid-frame change");
        s = done_count;
        apply_stimulus(1'b1);
        wait_char(5, 50, "midchg");
        #1;
        digits = 24'h999999;
        wait_frames(s + 1, 100, "midchg_cur");
        check_output("midchg_cur_line2", line_of(last_rx, 1), "   12:34:56     ");
        wait_frames(s + 2, 100, "midchg_next");
        check_output("midchg_next_line2", line_of(last_rx, 1), "   99:99:99     ");
        repeat (60) @(posedge clk);
        check_output("midchg_single_followup", done_count, s + 2);

        $display("[TB] reset mid-frame");
        s  = done_count;
        st = start_count;
        apply_stimulus(1'b1);
        wait_char(10, 50, "rst");
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("rst_outputs_low", {char_valid, frame_done, busy}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_frames(s + 1, 100, "rst_restart");
        repeat (5) @(posedge clk);
        check_output("rst_no_extra_done", done_count, s + 1);
        check_output("rst_start_count", start_count, st + 2);
        check_output("rst_duration", done_cyc - start_cyc, 32);
        check_output("rst_line1", line_of(last_rx, 0), "      CLOCK     ");
        check_output("rst_line2", line_of(last_rx, 1), "   99:99:99     ");

        $display("[TB] hex overflow instance");
        check_output("hex_accepts", hx_accepts, 32);
        check_output("hex_line1", line_of(hx_rx, 0), "   HEX TEST     ");
        check_output("hex_line2", line_of(hx_rx, 1), "   A:0:B:1:C:2:D");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
